// File: rtl/digital_lock_pkg.sv
// Shared types and constants for the keypad lock controller.
package digital_lock_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StEntry,
      StUnlocked,
      StFail,
      StLockout
   } lock_state_t;

   localparam logic [2:0] RGB_OFF   = 3'b000;
   localparam logic [2:0] RGB_RED   = 3'b100;
   localparam logic [2:0] RGB_GREEN = 3'b010;
   localparam logic [2:0] RGB_BLUE  = 3'b001;

   localparam logic [3:0] LED_OFF   = 4'b0000;
   localparam logic [3:0] LED_ALL   = 4'b1111;
   localparam logic [3:0] LED_ALT_A = 4'b1010;
   localparam logic [3:0] LED_ALT_B = 4'b0101;

   // Counter width that never collapses to zero bits.
   function automatic int unsigned clog2_min1(input int unsigned v);
      return (v <= 2) ? 1 : $clog2(v);
   endfunction

   function automatic logic [3:0] led_thermo(input int unsigned n);
      if (n >= 4) begin
         return LED_ALL;
      end
      return 4'((1 << n) - 1);
   endfunction

endpackage

// File: rtl/digital_lock_ctrl_if.sv
// Keypad/status bundle between the lock controller and its surroundings.
interface digital_lock_ctrl_if #(
   parameter int unsigned NUM_KEYS  = 4,
   parameter int unsigned CODE_LEN  = 4,
   parameter int unsigned MAX_FAILS = 3
) ();

   localparam int unsigned KEY_W  = digital_lock_pkg::clog2_min1(NUM_KEYS);
   localparam int unsigned FCNT_W = digital_lock_pkg::clog2_min1(MAX_FAILS + 1);

   logic [NUM_KEYS-1:0]       key;
   logic [CODE_LEN*KEY_W-1:0] code;
   logic                      relock;
   logic                      unlocked;
   logic                      alarm;
   logic [FCNT_W-1:0]         fail_cnt;
   logic [3:0]                led;
   logic [2:0]                rgb;

   modport master (
      output key, code, relock,
      input  unlocked, alarm, fail_cnt, led, rgb
   );

   modport slave (
      input  key, code, relock,
      output unlocked, alarm, fail_cnt, led, rgb
   );

endinterface

// File: rtl/lock_tick_gen.sv
// Blink tick divider: one-cycle pulse every CLK_FREQ/BLINK_HZ cycles, synchronous clear.
module lock_tick_gen
   import digital_lock_pkg::*;
#(
   parameter int unsigned CLK_FREQ = 125_000_000,
   parameter int unsigned BLINK_HZ = 25
) (
   input  logic clk,
   input  logic rst,
   input  logic clr_i,
   output logic tick_o
);

   localparam int unsigned DIV   = (CLK_FREQ / BLINK_HZ == 0) ? 1 : CLK_FREQ / BLINK_HZ;
   localparam int unsigned CNT_W = clog2_min1(DIV);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tick_o = (cnt_q == CNT_W'(DIV - 1));

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      if (clr_i || tick_o) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/digital_lock_ctrl.sv
// Keypad lock controller: code matching, failure counting, timed lockout and blink outputs.
// Optional ENTRY idle timeout enabled by defining DIGITAL_LOCK_ENTRY_TIMEOUT_EN.
module digital_lock_ctrl
   import digital_lock_pkg::*;
#(
   parameter int unsigned NUM_KEYS            = 4,
   parameter int unsigned CODE_LEN            = 4,
   parameter int unsigned MAX_FAILS           = 3,
   parameter int unsigned CLK_FREQ            = 125_000_000,
   parameter int unsigned BLINK_HZ            = 25,
   parameter int unsigned FAIL_TICKS          = 50,
   parameter int unsigned LOCKOUT_TICKS       = 250,
   parameter int unsigned ENTRY_TIMEOUT_TICKS = 125
) (
   input logic                clk,
   input logic                rst,
   digital_lock_ctrl_if.slave bus
);

   localparam int unsigned KEY_W     = clog2_min1(NUM_KEYS);
   localparam int unsigned FCNT_W    = clog2_min1(MAX_FAILS + 1);
   localparam int unsigned IDX_W     = clog2_min1(CODE_LEN + 1);
   localparam int unsigned TMAX_A    = (FAIL_TICKS > LOCKOUT_TICKS) ? FAIL_TICKS : LOCKOUT_TICKS;
   localparam int unsigned TIMER_MAX = (TMAX_A > ENTRY_TIMEOUT_TICKS) ? TMAX_A
                                                                    : ENTRY_TIMEOUT_TICKS;
   localparam int unsigned TMR_W     = clog2_min1(TIMER_MAX + 1);

   lock_state_t       state_q, state_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic              mismatch_q, mismatch_d;
   logic [FCNT_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic              blink_q, blink_d;
   logic [3:0]        led_q, led_d;
   logic [2:0]        rgb_q, rgb_d;
   logic              unlocked_q, unlocked_d;
   logic              alarm_q, alarm_d;

   logic              press, multi, digit_bad, mm_next, last_digit, tick, tick_clr;
   logic [KEY_W-1:0]  digit, exp_digit;
   logic [FCNT_W-1:0] fail_nxt;

   lock_tick_gen #(
      .CLK_FREQ(CLK_FREQ),
      .BLINK_HZ(BLINK_HZ)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clr_i (tick_clr),
      .tick_o(tick)
   );

   // Key decode; a second set bit marks the digit invalid.
   always_comb begin
      digit = '0;
      multi = 1'b0;
      press = 1'b0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (bus.key[i]) begin
            if (press) begin
               multi = 1'b1;
            end
            press = 1'b1;
            digit = KEY_W'(i);
         end
      end
   end

   always_comb begin
      exp_digit = '0;
      for (int j = 0; j < CODE_LEN; j++) begin
         if (idx_q == IDX_W'(j)) begin
            exp_digit = bus.code[j*KEY_W +: KEY_W];
         end
      end
   end

   assign digit_bad  = multi || (digit != exp_digit);
   assign mm_next    = mismatch_q || digit_bad;
   assign last_digit = (idx_q == IDX_W'(CODE_LEN - 1));
   assign fail_nxt   = (fail_cnt_q == FCNT_W'(MAX_FAILS)) ? fail_cnt_q : fail_cnt_q + 1'b1;

   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      mismatch_d = mismatch_q;
      fail_cnt_d = fail_cnt_q;
      timer_d    = timer_q;
      blink_d    = blink_q;
      tick_clr   = 1'b0;

      unique case (state_q)
         // IDLE and ENTRY share the digit path: idx and mismatch are zero in IDLE.
         StIdle, StEntry: begin
            if (press) begin
               tick_clr = 1'b1;
               timer_d  = '0;
               blink_d  = 1'b0;
               if (last_digit) begin
                  idx_d      = '0;
                  mismatch_d = 1'b0;
                  if (!mm_next) begin
                     state_d    = StUnlocked;
                     fail_cnt_d = '0;
                  end else begin
                     fail_cnt_d = fail_nxt;
                     state_d    = (fail_nxt == FCNT_W'(MAX_FAILS)) ? StLockout : StFail;
                  end
               end else begin
                  idx_d      = idx_q + 1'b1;
                  mismatch_d = mm_next;
                  state_d    = StEntry;
               end
            end
`ifdef DIGITAL_LOCK_ENTRY_TIMEOUT_EN
            else if ((state_q == StEntry) && tick) begin
               if (timer_q == TMR_W'(ENTRY_TIMEOUT_TICKS - 1)) begin
                  state_d    = StIdle;
                  idx_d      = '0;
                  mismatch_d = 1'b0;
                  timer_d    = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
`endif
         end
         StUnlocked: begin
            if (bus.relock) begin
               state_d = StIdle;
            end
         end
         StFail: begin
            if (tick) begin
               blink_d = ~blink_q;
               timer_d = timer_q + 1'b1;
               if (timer_q == TMR_W'(FAIL_TICKS - 1)) begin
                  state_d = StIdle;
                  timer_d = '0;
               end
            end
         end
         StLockout: begin
            if (tick) begin
               blink_d = ~blink_q;
               timer_d = timer_q + 1'b1;
               if (timer_q == TMR_W'(LOCKOUT_TICKS - 1)) begin
                  state_d    = StIdle;
                  timer_d    = '0;
                  fail_cnt_d = '0;
               end
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs are decoded from next state so they register alongside it.
   always_comb begin
      led_d      = LED_OFF;
      rgb_d      = RGB_OFF;
      unlocked_d = 1'b0;
      alarm_d    = 1'b0;
      unique case (state_d)
         StIdle: begin
            led_d = LED_OFF;
            rgb_d = RGB_OFF;
         end
         StEntry: begin
            led_d = led_thermo(int'(idx_d));
            rgb_d = RGB_BLUE;
         end
         StUnlocked: begin
            led_d      = LED_ALL;
            rgb_d      = RGB_GREEN;
            unlocked_d = 1'b1;
         end
         StFail: begin
            led_d = blink_d ? LED_OFF : LED_ALL;
            rgb_d = blink_d ? RGB_OFF : RGB_RED;
         end
         StLockout: begin
            led_d   = blink_d ? LED_ALT_B : LED_ALT_A;
            rgb_d   = blink_d ? RGB_BLUE : RGB_RED;
            alarm_d = 1'b1;
         end
         default: begin
            led_d = LED_OFF;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= StIdle;
         idx_q      <= '0;
         mismatch_q <= 1'b0;
         fail_cnt_q <= '0;
         timer_q    <= '0;
         blink_q    <= 1'b0;
         led_q      <= LED_OFF;
         rgb_q      <= RGB_OFF;
         unlocked_q <= 1'b0;
         alarm_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         mismatch_q <= mismatch_d;
         fail_cnt_q <= fail_cnt_d;
         timer_q    <= timer_d;
         blink_q    <= blink_d;
         led_q      <= led_d;
         rgb_q      <= rgb_d;
         unlocked_q <= unlocked_d;
         alarm_q    <= alarm_d;
      end
   end

   assign bus.unlocked = unlocked_q;
   assign bus.alarm    = alarm_q;
   assign bus.fail_cnt = fail_cnt_q;
   assign bus.led      = led_q;
   assign bus.rgb      = rgb_q;

endmodule

// File: tb/tb_digital_lock_ctrl.sv
// Scoreboard bench for digital_lock_ctrl: stimulus queues timed expectations, a monitor checks them.
module tb_digital_lock_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   digital_lock_ctrl_if #(
      .NUM_KEYS (4),
      .CODE_LEN (4),
      .MAX_FAILS(3)
   ) bus ();

   digital_lock_ctrl #(
      .NUM_KEYS           (4),
      .CODE_LEN           (4),
      .MAX_FAILS          (3),
      .CLK_FREQ           (1000),
      .BLINK_HZ           (50),
      .FAIL_TICKS         (4),
      .LOCKOUT_TICKS      (10),
      .ENTRY_TIMEOUT_TICKS(5)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   typedef struct {
      int         c;
      string      name;
      logic       u;
      logic       a;
      logic [1:0] fc;
      logic [3:0] led;
      logic [2:0] rgb;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   fc_model = 0;
   int   entry_cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic push_exp(input int c, input string name, input logic u, input logic a,
                           input logic [3:0] led, input logic [2:0] rgb);
      exp_t e;
      e.c = c; e.name = name; e.u = u; e.a = a; e.fc = 2'(fc_model);
      e.led = led; e.rgb = rgb;
      q.push_back(e);
   endtask

   task automatic exp_idle(input int c, input string name);
      push_exp(c, name, 1'b0, 1'b0, 4'b0000, 3'b000);
   endtask

   task automatic exp_entry(input int c, input string name, input int n);
      logic [3:0] th;
      th = (n >= 4) ? 4'b1111 : 4'((1 << n) - 1);
      push_exp(c, name, 1'b0, 1'b0, th, 3'b001);
   endtask

   task automatic exp_unl(input int c, input string name);
      push_exp(c, name, 1'b1, 1'b0, 4'b1111, 3'b010);
   endtask

   task automatic exp_fail(input int c, input string name, input bit ph);
      push_exp(c, name, 1'b0, 1'b0, ph ? 4'b0000 : 4'b1111, ph ? 3'b000 : 3'b100);
   endtask

   task automatic exp_lock(input int c, input string name, input bit ph);
      push_exp(c, name, 1'b0, 1'b1, ph ? 4'b0101 : 4'b1010, ph ? 3'b001 : 3'b100);
   endtask

   task automatic press(input logic [3:0] k);
      bus.key = k;
      @(negedge clk);
      bus.key = '0;
   endtask

   task automatic relock_pulse(input logic [3:0] k);
      bus.relock = 1'b1;
      bus.key    = k;
      @(negedge clk);
      bus.relock = 1'b0;
      bus.key    = '0;
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic send_code(input logic [3:0] k0, input logic [3:0] k1, input logic [3:0] k2,
                            input logic [3:0] k3, input bit good);
      exp_entry(cyc + 1, "entry_d0", 1);
      press(k0);
      exp_entry(cyc + 1, "entry_d1", 2);
      press(k1);
      exp_entry(cyc + 1, "entry_d2", 3);
      press(k2);
      if (good) begin
         fc_model = 0;
         exp_unl(cyc + 1, "unlock");
      end else begin
         fc_model = fc_model + 1;
         if (fc_model == 3) exp_lock(cyc + 1, "lockout_enter", 1'b0);
         else exp_fail(cyc + 1, "fail_enter", 1'b0);
      end
      press(k3);
      entry_cyc = cyc;
   endtask

   task automatic fail_window();
      int e;
      e = entry_cyc;
      exp_fail(e + 19, "fail_pre_toggle", 1'b0);
      exp_fail(e + 20, "fail_toggle1", 1'b1);
      wait_until(e + 25);
      exp_fail(e + 26, "fail_key_ignored", 1'b1);
      press(4'b0010);
      exp_fail(e + 40, "fail_toggle2", 1'b0);
      exp_fail(e + 79, "fail_last", 1'b1);
      exp_idle(e + 80, "fail_exit");
      wait_until(e + 80);
   endtask

   task automatic lockout_window();
      int e;
      e = entry_cyc;
      exp_lock(e + 19, "lock_pre_toggle", 1'b0);
      exp_lock(e + 20, "lock_toggle1", 1'b1);
      wait_until(e + 30);
      exp_lock(e + 31, "lock_key_ignored", 1'b1);
      press(4'b0010);
      wait_until(e + 50);
      exp_lock(e + 51, "lock_relock_ignored", 1'b0);
      relock_pulse(4'b0000);
      exp_lock(e + 199, "lock_last", 1'b1);
      fc_model = 0;
      exp_idle(e + 200, "lock_exit");
      wait_until(e + 200);
   endtask

   // Monitor: compares every queued expectation on the cycle it falls due.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         while (q.size() > 0 && q[0].c <= cyc) begin
            e = q.pop_front();
            n_tests++;
            if (e.c != cyc || bus.unlocked !== e.u || bus.alarm !== e.a ||
                bus.fail_cnt !== e.fc || bus.led !== e.led || bus.rgb !== e.rgb) begin
               n_fail++;
               $display("FAIL %s cyc=%0d due=%0d got u=%b a=%b fc=%0d led=%b rgb=%b want u=%b a=%b fc=%0d led=%b rgb=%b",
                        e.name, cyc, e.c, bus.unlocked, bus.alarm, bus.fail_cnt, bus.led,
                        bus.rgb, e.u, e.a, e.fc, e.led, e.rgb);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog cyc=%0d pending=%0d", cyc, q.size());
      $fatal(1);
   end

   initial begin
      int p;
      int guard;
      bus.key    = '0;
      bus.relock = 1'b0;
      bus.code   = 8'b00_01_10_01;
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      exp_idle(cyc + 1, "in_reset");
      @(negedge clk);
      rst = 1'b1;
      exp_idle(cyc + 1, "post_reset");
      @(negedge clk);

      // Correct code, ignored key while unlocked, relock.
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b0001, 1'b1);
      exp_unl(cyc + 1, "unl_key_ignored");
      press(4'b1000);
      exp_idle(cyc + 1, "relock");
      relock_pulse(4'b0000);
      exp_idle(cyc + 1, "idle_relock_ignored");
      relock_pulse(4'b0000);

      // relock together with a press: press dropped.
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b0001, 1'b1);
      exp_idle(cyc + 1, "relock_with_press");
      relock_pulse(4'b0010);

      // Wrong digit 3 at position 2, then multi-bit key, then lockout.
      send_code(4'b0010, 4'b0100, 4'b1000, 4'b0001, 1'b0);
      fail_window();
      send_code(4'b0011, 4'b0100, 4'b0010, 4'b0001, 1'b0);
      fail_window();
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b1000, 1'b0);
      lockout_window();

      // Two failures then success clears the count.
      send_code(4'b0010, 4'b0011, 4'b0010, 4'b0001, 1'b0);
      fail_window();
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b0011, 1'b0);
      fail_window();
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b0001, 1'b1);
      exp_idle(cyc + 1, "relock2");
      relock_pulse(4'b0000);

      // Partial entry with a failure already counted.
      send_code(4'b0001, 4'b0100, 4'b0010, 4'b0001, 1'b0);
      fail_window();
      exp_entry(cyc + 1, "partial_d0", 1);
      press(4'b0010);
      exp_entry(cyc + 1, "partial_d1", 2);
      press(4'b0100);
      p = cyc;
`ifdef DIGITAL_LOCK_ENTRY_TIMEOUT_EN
      exp_entry(p + 99, "timeout_pending", 2);
      exp_idle(p + 100, "timeout_idle");
      wait_until(p + 100);
`else
      exp_entry(p + 100, "no_timeout", 2);
      wait_until(p + 100);
      exp_entry(cyc + 1, "partial_d2", 3);
      press(4'b0010);
      fc_model = 0;
      exp_unl(cyc + 1, "partial_unlock");
      press(4'b0001);
      exp_idle(cyc + 1, "relock3");
      relock_pulse(4'b0000);
`endif

      // Asynchronous reset during lockout.
      while (fc_model < 2) begin
         send_code(4'b0100, 4'b0100, 4'b0010, 4'b0001, 1'b0);
         fail_window();
      end
      send_code(4'b0100, 4'b0100, 4'b0010, 4'b0001, 1'b0);
      exp_lock(entry_cyc + 10, "lock_before_reset", 1'b0);
      wait_until(entry_cyc + 10);
      fc_model = 0;
      exp_idle(cyc + 1, "async_reset");
      @(posedge clk);
      #2 rst = 1'b0;
      @(negedge clk);
      exp_idle(cyc + 1, "held_reset");
      @(negedge clk);
      rst = 1'b1;
      send_code(4'b0010, 4'b0100, 4'b0010, 4'b0001, 1'b1);
      exp_idle(cyc + 1, "relock_final");
      relock_pulse(4'b0000);

      guard = 0;
      while (q.size() > 0 && guard < 100) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL scoreboard_drain pending=%0d want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/digital_lock_ctrl.md
# digital_lock_ctrl

Parametrised keypad lock controller: the next generation of the board-level digital lock. It accepts debounced single-cycle key pulses, matches a CODE_LEN-digit sequence over NUM_KEYS keys and counts consecutive failures. After MAX_FAILS failures it enters a timed alarm lockout. Blink generation for LEDs and RGB is internal, so the top level only wires debounce, pulse detection and this block.

## Interface
- NUM_KEYS, 4: key count; KEY_W = $clog2(NUM_KEYS) bits per digit (min 1)
- CODE_LEN, 4: digits per code, ≥1
- MAX_FAILS, 3: consecutive failures that trigger lockout, ≥1
- CLK_FREQ, 125_000_000: clk frequency, Hz
- BLINK_HZ, 25: blink tick rate; one tick every CLK_FREQ/BLINK_HZ cycles
- FAIL_TICKS, 50: ticks spent in FAIL
- LOCKOUT_TICKS, 250: ticks spent in LOCKOUT
- ENTRY_TIMEOUT_TICKS, 125: idle ticks before ENTRY is abandoned (macro-gated)
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- key  in  NUM_KEYS  one-hot single-cycle key pulses; more than one bit set is an invalid digit
- code  in  CODE_LEN*KEY_W  expected key indices, digit 0 in LSBs; sampled per digit, must be static during entry
- relock  in  1  single-cycle pulse, UNLOCKED → IDLE
- unlocked  out  1  high in UNLOCKED
- alarm  out  1  high in LOCKOUT
- fail_cnt  out  $clog2(MAX_FAILS+1)  consecutive failures
- led  out  4  status LEDs
- rgb  out  3  {R,G,B}

## Operation
- press = |key. Digit value = index of the set bit. Multi-bit key = press with forced mismatch.
- States: IDLE, ENTRY, UNLOCKED, FAIL, LOCKOUT.
- IDLE: press → ENTRY. idx=1. mismatch = (digit ≠ code[0]).
- ENTRY: each press compares against code[idx], ORs the result into mismatch, then idx++. At the CODE_LEN-th press, evaluation uses the final mismatch including that digit:
  - clean: → UNLOCKED, fail_cnt=0.
  - else: fail_cnt++. If the new count equals MAX_FAILS → LOCKOUT, otherwise → FAIL.
  - CODE_LEN=1: the IDLE press evaluates directly.
- UNLOCKED: keys ignored. relock → IDLE.
- FAIL: keys ignored. After FAIL_TICKS ticks → IDLE.
- LOCKOUT: keys and relock ignored. After LOCKOUT_TICKS ticks → IDLE, fail_cnt=0.
- relock outside UNLOCKED is ignored.
- fail_cnt saturates at MAX_FAILS. It clears only on success or at lockout expiry.
- Outputs per state:
  - IDLE: led 0000, rgb 000.
  - ENTRY: led = thermometer of min(idx,4), rgb 001.
  - UNLOCKED: led 1111, rgb 010.
  - FAIL: led toggles 1111/0000 per tick starting 1111; rgb toggles 100/000 starting 100.
  - LOCKOUT: led toggles 1010/0101 starting 1010; rgb toggles 100/001 starting 100.

## Timing
- Reset values: state IDLE, idx 0, mismatch 0, fail_cnt 0, led 0000, rgb 000, unlocked 0, alarm 0, tick divider 0, tick timer 0.
- All outputs are registered. A press sampled at edge k changes state and outputs at k+1.
- Tick divider and tick timer clear on entry to ENTRY, FAIL and LOCKOUT, so blink phase starts deterministically. First toggle occurs CLK_FREQ/BLINK_HZ cycles after entry.
- FAIL/LOCKOUT exit occurs on the cycle the N-th tick is counted.
- Press and timeout expiry in the same cycle: the press wins.
- relock and press together in UNLOCKED: → IDLE, and the press is dropped.
- Reset asserted mid-operation returns everything to reset values immediately, including fail_cnt.

## Configuration
- DIGITAL_LOCK_ENTRY_TIMEOUT_EN defined: in ENTRY, ENTRY_TIMEOUT_TICKS ticks with no press → IDLE. Partial entry is discarded and fail_cnt is unchanged. Each press clears the timer.
- Undefined: ENTRY waits indefinitely, and ENTRY_TIMEOUT_TICKS is unused.

## Structure
- digital_lock_pkg holds:
  - state enum lock_state_t
  - RGB constants RGB_OFF/RED/GREEN/BLUE
  - LED pattern constants
- Sub-module lock_tick_gen: parametrised CLK_FREQ/BLINK_HZ divider with synchronous clear input. Produces a one-cycle tick pulse.

## Test plan
Bench params: CLK_FREQ=1000, BLINK_HZ=50 (tick every 20 cycles), CODE_LEN=4, NUM_KEYS=4, MAX_FAILS=3, FAIL_TICKS=4, LOCKOUT_TICKS=10, ENTRY_TIMEOUT_TICKS=5, code digits 1,2,1,0.
- Correct code, keys 0010,0100,0010,0001 → unlocked=1, led 1111, rgb 010 one cycle after the 4th press; relock → IDLE, led 0000.
- Wrong digit 3 at position 2 → FAIL after the 4th press, fail_cnt=1, rgb toggles 100/000 every 20 cycles, IDLE after 80 cycles.
- Three wrong codes → LOCKOUT, alarm=1, led alternates 1010/0101. Presses during lockout are ignored. IDLE with fail_cnt=0 after 200 cycles.
- Two failures then the correct code → fail_cnt returns to 0. A multi-bit key (0011) in any position yields FAIL.
- With macro defined: two presses then 100 quiet cycles → IDLE, fail_cnt unchanged. Without macro: ENTRY persists.
- Reset low during LOCKOUT → all outputs 0 asynchronously, fail_cnt=0. After release, the correct code unlocks.
